// File: rtl/spi_pkg.sv
// Shared definitions for the pixel-pipeline SPI link (spi_out transmitter, spi_in receiver).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_tx_state_t;

    localparam int SPI_LANES         = 2;
    localparam int SPI_BITS_PER_LANE = 16;

    // Pixel word layout: {7'b0, is_mandelbrot, color[23:0]}
    localparam int PIX_FLAG_BIT  = 24;
    localparam int PIX_COLOR_MSB = 23;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter: one-cycle half_tick every CLK_DIV cycles while enabled, cleared when disabled.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic half_tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = (cnt == CW'(CLK_DIV - 1));
    assign half_tick = en && wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/spi_out.sv
// SPI mode-0 transmitter: one-entry holding buffer feeding a multi-lane MSB-first shifter
// with generated spi_clk and active-low chip select.
module spi_out
    import spi_pkg::*;
#(
    parameter int LANES         = SPI_LANES,
    parameter int BITS_PER_LANE = SPI_BITS_PER_LANE,
    parameter int CLK_DIV       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic [LANES*BITS_PER_LANE-1:0] data_in,
    output logic                           ready_out,
    output logic                           spi_clk,
    output logic                           spi_cs_n,
    output logic [LANES-1:0]               spi_data,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int N  = BITS_PER_LANE;
    localparam int BW = $clog2(BITS_PER_LANE) + 1;

    spi_tx_state_t state, state_next;

    logic                      buf_full, buf_full_d;
    logic [LANES-1:0][N-1:0]   buf_data;
    logic [LANES-1:0][N-1:0]   sh;
    logic [BW-1:0]             bit_cnt;
    logic                      tick, last_rise;
    logic                      accept, load, shift_en, rise;
    logic                      spi_clk_d, cs_n_d, busy_d, frame_done_d;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state != IDLE),
        .half_tick (tick)
    );

    assign last_rise = (bit_cnt == BW'(N));
    assign ready_out = ~buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (buf_full)                         state_next = SETUP;
            SETUP: if (tick)                             state_next = SHIFT;
            SHIFT: if (tick && !spi_clk && last_rise)    state_next = HOLD;
            HOLD:  if (tick)                             state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    always_comb begin
        accept       = valid_in && ready_out;
        load         = (state == IDLE) && buf_full;
        shift_en     = (state == SHIFT) && tick && spi_clk && !last_rise;
        rise         = tick && ((state == SETUP) ||
                                ((state == SHIFT) && !spi_clk && !last_rise));
        frame_done_d = (state == HOLD) && tick;
        cs_n_d       = (state_next == IDLE);
        spi_clk_d    = 1'b0;
        case (state)
            SETUP:   spi_clk_d = tick;
            // The final low phase after the N-th rise stays in SHIFT; HOLD starts after it.
            SHIFT:   spi_clk_d = tick ? ((state_next == SHIFT) && !spi_clk) : spi_clk;
            default: spi_clk_d = 1'b0;
        endcase
        buf_full_d = load ? 1'b0 : (accept ? 1'b1 : buf_full);
        busy_d     = ~cs_n_d | buf_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full   <= 1'b0;
            buf_data   <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            spi_clk    <= 1'b0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            buf_full   <= buf_full_d;
            spi_clk    <= spi_clk_d;
            spi_cs_n   <= cs_n_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            if (accept)
                buf_data <= data_in;
            if (load)
                bit_cnt <= '0;
            else if (rise)
                bit_cnt <= bit_cnt + 1'b1;
            if (load)
                sh <= buf_data;
            else if (shift_en)
                for (int i = 0; i < LANES; i++) sh[i] <= sh[i] << 1;
            else if (frame_done_d)
                sh <= '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign spi_data[i] = sh[i][N-1];
    end

endmodule
